// File: rtl/nes_poll_pkg.sv
// nes_poll_pkg: shared state encoding, button indices and 64 MHz timing defaults
package nes_poll_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_GAP, S_CLK_HI, S_CLK_LO, S_PUBLISH
  } state_t;
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int DEF_LATCH_CYCLES = 768;
  localparam int DEF_HALF_CYCLES  = 384;
  localparam int DEF_POLL_PERIOD  = 1066667;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/nes_poll_timer.sv
// nes_poll_timer: enable-gated period counter, ticks on the last count of each period
module nes_poll_timer
  import nes_poll_pkg::*;
#(
  parameter int POLL_PERIOD = DEF_POLL_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic i_enable,
  output logic o_tick
);
  localparam int TW = $clog2(POLL_PERIOD) > 0 ? $clog2(POLL_PERIOD) : 1;
  logic [TW-1:0] r_count;
  logic          w_last;
  assign w_last = r_count == TW'(POLL_PERIOD - 1);
  assign o_tick = i_enable && w_last;
  always_ff @(posedge clk)
    if (reset || !i_enable) r_count <= '0;
    else r_count <= w_last ? '0 : r_count + 1'b1;
endmodule

// File: rtl/nes_poll_scheduler.sv
// nes_poll_scheduler: drives shared latch/clock to two NES pads and publishes
// an atomic two-pad snapshot after every poll.
module nes_poll_scheduler
  import nes_poll_pkg::*;
#(
  parameter int LATCH_CYCLES = DEF_LATCH_CYCLES,
  parameter int HALF_CYCLES  = DEF_HALF_CYCLES,
  parameter int POLL_PERIOD  = DEF_POLL_PERIOD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       trigger,
  input  logic       overrun_clr,
  input  logic       nes_data0,
  input  logic       nes_data1,
  output logic       nes_latch,
  output logic       nes_clk,
  output logic [7:0] buttons0,
  output logic [7:0] buttons1,
  output logic       valid,
  output logic       changed,
  output logic       busy,
  output logic       overrun
);
  localparam int CMAX = max2(LATCH_CYCLES, HALF_CYCLES);
  localparam int CW   = $clog2(CMAX) > 0 ? $clog2(CMAX) : 1;
  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift0, r_shift1, r_btn0, r_btn1;
  logic          r_latch, r_nclk, r_valid, r_changed, r_busy, r_overrun;
  logic          w_tick, w_req, w_latch_done, w_half_done, w_sample, w_pub, w_chg;
  nes_poll_timer #(.POLL_PERIOD(POLL_PERIOD)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .i_enable (enable),
    .o_tick   (w_tick)
  );
  assign w_req        = (enable & w_tick) | trigger;
  assign w_latch_done = r_cnt == CW'(LATCH_CYCLES - 1);
  assign w_half_done  = r_cnt == CW'(HALF_CYCLES - 1);
  // Bit 0 is already on the data lines once latch drops; later bits just before nes_clk falls
  assign w_sample = (r_state == S_GAP && r_cnt == '0) || (r_state == S_CLK_HI && w_half_done);
  assign w_pub    = w_next == S_PUBLISH;
  assign w_chg    = (~r_shift0 != r_btn0) || (~r_shift1 != r_btn1);
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    w_next = w_req ? S_LATCH : S_IDLE;
      S_LATCH:   w_next = w_latch_done ? S_GAP : S_LATCH;
      S_GAP:     w_next = w_half_done ? S_CLK_HI : S_GAP;
      S_CLK_HI:  w_next = w_half_done ? S_CLK_LO : S_CLK_HI;
      S_CLK_LO:  w_next = !w_half_done ? S_CLK_LO : (r_bit == 3'd7) ? S_PUBLISH : S_CLK_HI;
      S_PUBLISH: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_shift0  <= '0;
      r_shift1  <= '0;
      r_btn0    <= '0;
      r_btn1    <= '0;
      r_latch   <= 1'b0;
      r_nclk    <= 1'b0;
      r_valid   <= 1'b0;
      r_changed <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_cnt     <= (w_next != r_state || r_state == S_IDLE) ? '0 : r_cnt + 1'b1;
      r_bit     <= (r_state == S_IDLE) ? '0 :
                   (w_next == S_CLK_HI && r_state != S_CLK_HI) ? r_bit + 1'b1 : r_bit;
      if (w_sample) begin
        r_shift0[r_bit] <= nes_data0;
        r_shift1[r_bit] <= nes_data1;
      end
      if (w_pub) begin
        r_btn0 <= ~r_shift0;
        r_btn1 <= ~r_shift1;
      end
      r_latch   <= w_next == S_LATCH;
      r_nclk    <= w_next == S_CLK_HI;
      r_valid   <= w_pub;
      r_changed <= w_pub && w_chg;
      r_busy    <= w_next != S_IDLE;
      r_overrun <= (w_req && r_busy) || (r_overrun && !overrun_clr);
    end
  assign nes_latch = r_latch;
  assign nes_clk   = r_nclk;
  assign buttons0  = r_btn0;
  assign buttons1  = r_btn1;
  assign valid     = r_valid;
  assign changed   = r_changed;
  assign busy      = r_busy;
  assign overrun   = r_overrun;
endmodule

// File: tb/tb_nes_poll_scheduler.sv
// tb_nes_poll_scheduler: directed checks of waveform, snapshot, periodic, overrun and reset behaviour
module tb_nes_poll_scheduler;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b0, trigger = 1'b0, overrun_clr = 1'b0;
  logic nes_data0 = 1'b1, nes_data1 = 1'b1;
  logic nes_latch, nes_clk, valid, changed, busy, overrun;
  logic [7:0] buttons0, buttons1;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  nes_poll_scheduler #(.LATCH_CYCLES(4), .HALF_CYCLES(2), .POLL_PERIOD(100)) dut (
    .clk(clk), .reset(reset), .enable(enable), .trigger(trigger), .overrun_clr(overrun_clr),
    .nes_data0(nes_data0), .nes_data1(nes_data1), .nes_latch(nes_latch), .nes_clk(nes_clk),
    .buttons0(buttons0), .buttons1(buttons1), .valid(valid), .changed(changed),
    .busy(busy), .overrun(overrun)
  );
  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle timeout busy=%b required 0", name, busy);
    end
  endtask
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({nes_latch, nes_clk, buttons0, buttons1, valid, changed, busy, overrun} !== 22'd0) begin
      errors++;
      $display("FAIL reset_values got %b required 0",
               {nes_latch, nes_clk, buttons0, buttons1, valid, changed, busy, overrun});
    end
    reset = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      checks++;
      if ({nes_latch, nes_clk, valid, busy} !== 4'b0000) begin
        errors++;
        $display("FAIL idle_quiet c=%0d latch/clk/valid/busy=%b required 0000", c,
                 {nes_latch, nes_clk, valid, busy});
      end
    end
    checks++;
    if ({buttons0, buttons1} !== 16'h0000) begin
      errors++;
      $display("FAIL idle_buttons got %h required 0000", {buttons0, buttons1});
    end
  endtask
  task automatic test_poll(input string name, input logic [7:0] p0, input logic [7:0] p1,
                           input logic [7:0] old0, input logic [7:0] old1, input logic exp_chg);
    @(negedge clk) trigger = 1'b1;
    @(negedge clk) trigger = 1'b0;
    for (int c = 0; c < 40; c++) begin
      int b;
      logic el, ec, ev, eb;
      b  = c < 6 ? 0 : (c - 6) / 4 + 1;
      if (b > 7) b = 7;
      el = c < 4;
      ec = c >= 6 && c < 34 && ((c - 6) % 4) < 2;
      ev = c == 34;
      eb = c <= 34;
      checks++;
      if ({nes_latch, nes_clk, valid, busy} !== {el, ec, ev, eb}) begin
        errors++;
        $display("FAIL %s wave c=%0d latch/clk/valid/busy=%b required %b", name, c,
                 {nes_latch, nes_clk, valid, busy}, {el, ec, ev, eb});
      end
      checks++;
      if ({buttons0, buttons1} !== (c >= 34 ? {p0, p1} : {old0, old1})) begin
        errors++;
        $display("FAIL %s buttons c=%0d got %h required %h", name, c, {buttons0, buttons1},
                 c >= 34 ? {p0, p1} : {old0, old1});
      end
      checks++;
      if (changed !== (ev & exp_chg)) begin
        errors++;
        $display("FAIL %s changed c=%0d got %b required %b", name, c, changed, ev & exp_chg);
      end
      nes_data0 = ~p0[b];
      nes_data1 = ~p1[b];
      @(negedge clk);
    end
    nes_data0 = 1'b1;
    nes_data1 = 1'b1;
  endtask
  task automatic test_overrun();
    int nv = 0;
    @(negedge clk) trigger = 1'b1;
    @(negedge clk) trigger = 1'b0;
    repeat (5) @(negedge clk);
    trigger = 1'b1;
    @(negedge clk) trigger = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set got %b required 1", overrun);
    end
    for (int c = 0; c < 80; c++) begin
      if (valid === 1'b1) nv++;
      @(negedge clk);
    end
    checks++;
    if (nv != 1) begin
      errors++;
      $display("FAIL overrun_single_poll valid pulses %0d required 1", nv);
    end
    overrun_clr = 1'b1;
    @(negedge clk) overrun_clr = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear got %b required 0", overrun);
    end
    @(negedge clk) trigger = 1'b1;
    @(negedge clk) trigger = 1'b0;
    repeat (5) @(negedge clk);
    trigger = 1'b1;
    overrun_clr = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    overrun_clr = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set_wins got %b required 1", overrun);
    end
    wait_idle("overrun");
    overrun_clr = 1'b1;
    @(negedge clk) overrun_clr = 1'b0;
  endtask
  task automatic test_periodic();
    int rises[5];
    int n = 0;
    logic prev = 1'b0;
    enable = 1'b1;
    for (int c = 0; c < 650 && n < 5; c++) begin
      @(negedge clk);
      if (nes_latch === 1'b1 && !prev) begin
        rises[n] = c;
        n++;
      end
      prev = nes_latch;
    end
    enable = 1'b0;
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL periodic_count latch rises %0d required 5", n);
    end
    for (int i = 1; i < n; i++) begin
      checks++;
      if (rises[i] - rises[i-1] != 100) begin
        errors++;
        $display("FAIL periodic_spacing poll %0d got %0d required 100", i, rises[i] - rises[i-1]);
      end
    end
    wait_idle("periodic");
  endtask
  task automatic test_reset_mid_poll();
    @(negedge clk) trigger = 1'b1;
    @(negedge clk) trigger = 1'b0;
    repeat (14) @(negedge clk);
    checks++;
    if (nes_clk !== 1'b1) begin
      errors++;
      $display("FAIL midpoll_in_clk_hi got %b required 1", nes_clk);
    end
    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    checks++;
    if ({nes_latch, nes_clk, busy, valid, changed, buttons0, buttons1} !== 21'd0) begin
      errors++;
      $display("FAIL midpoll_reset got %b required 0",
               {nes_latch, nes_clk, busy, valid, changed, buttons0, buttons1});
    end
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      checks++;
      if ({valid, busy} !== 2'b00) begin
        errors++;
        $display("FAIL midpoll_no_publish c=%0d valid/busy=%b required 00", c, {valid, busy});
      end
    end
  endtask
  initial begin
    test_reset();
    test_poll("poll_first", 8'h89, 8'h00, 8'h00, 8'h00, 1'b1);
    test_poll("poll_repeat", 8'h89, 8'h00, 8'h89, 8'h00, 1'b0);
    test_overrun();
    test_periodic();
    test_poll("poll_back_to_back", 8'h89, 8'h42, 8'h00, 8'h00, 1'b1);
    test_reset_mid_poll();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
